// File: rtl/seg7_scan_capture.sv
// seg7_scan_capture - recovers an 8-digit hex frame from scanned 7-segment anode/segment lines.
// A digit is accepted once its {an,seg} sample holds for STABLE_CYCLES cycles, once per dwell.
module seg7_scan_capture #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 4,
   parameter int TIMEOUT       = 2**20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  an,
   input  logic [6:0]  seg,
   output logic [31:0] digits,
   output logic [7:0]  blank,
   output logic        frame_valid,
   output logic        bad_pattern,
   output logic        stale
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam int TW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {SEARCH, SETTLE, HELD} state_t;

   logic [14:0] s;

   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign s = {an, seg};
      end else begin : g_sync
         logic [SYNC_STAGES-1:0][14:0] sync_q, sync_d;
         always_comb begin
            sync_d[0] = {an, seg};
            for (int k = 1; k < SYNC_STAGES; k++) sync_d[k] = sync_q[k-1];
         end
         always_ff @(posedge clk) begin
            if (rst) sync_q <= '1;
            else     sync_q <= sync_d;
         end
         assign s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   // Returns {known, blank, value}
   function automatic logic [5:0] decode(input logic [6:0] code);
      case (code)
         7'h01: decode = {2'b10, 4'h0};
         7'h4F: decode = {2'b10, 4'h1};
         7'h12: decode = {2'b10, 4'h2};
         7'h06: decode = {2'b10, 4'h3};
         7'h4C: decode = {2'b10, 4'h4};
         7'h24: decode = {2'b10, 4'h5};
         7'h20: decode = {2'b10, 4'h6};
         7'h0F: decode = {2'b10, 4'h7};
         7'h00: decode = {2'b10, 4'h8};
         7'h04: decode = {2'b10, 4'h9};
         7'h08: decode = {2'b10, 4'hA};
         7'h60: decode = {2'b10, 4'hB};
         7'h31: decode = {2'b10, 4'hC};
         7'h42: decode = {2'b10, 4'hD};
         7'h30: decode = {2'b10, 4'hE};
         7'h38: decode = {2'b10, 4'hF};
         7'h7F: decode = {2'b11, 4'h0};
         default: decode = 6'b000000;
      endcase
   endfunction

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [14:0]   lat_q, lat_d;
   logic          valid_an;
   logic          accept;

   assign valid_an = $onehot(~s[14:7]);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEARCH;
         cnt_q   <= '0;
         lat_q   <= '1;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         lat_q   <= lat_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      lat_d   = lat_q;
      case (state_q)
         SETTLE: begin
            if (s == lat_q) begin
               cnt_d = cnt_q + CW'(1);
            end else if (valid_an) begin
               cnt_d = CW'(1);
               lat_d = s;
            end else begin
               state_d = SEARCH;
               cnt_d   = '0;
            end
         end
         default: begin
            // SEARCH and a disturbed HELD share the same re-evaluation
            if (state_q == SEARCH || s != lat_q) begin
               if (valid_an) begin
                  state_d = SETTLE;
                  cnt_d   = CW'(1);
                  lat_d   = s;
               end else begin
                  state_d = SEARCH;
                  cnt_d   = '0;
               end
            end
         end
      endcase
      if (state_d == SETTLE && cnt_d == CW'(STABLE_CYCLES)) state_d = HELD;
   end

   always_comb begin
      accept = (state_d == HELD) && (state_q != HELD || lat_d != lat_q);
   end

   logic [31:0]   dig_sh_q, dig_sh_d, digits_q, digits_d;
   logic [7:0]    blk_sh_q, blk_sh_d, blank_q, blank_d;
   logic [7:0]    seen_q, seen_d;
   logic [TW-1:0] tcnt_q, tcnt_d;
   logic          fv_q, fv_d, bad_q, bad_d, stale_q, stale_d;
   logic [5:0]    dec;
   logic [2:0]    idx;

   always_comb begin
      idx = '0;
      for (int k = 0; k < 8; k++) if (!lat_d[7+k]) idx = 3'(k);
      dec = decode(lat_d[6:0]);

      dig_sh_d = dig_sh_q;
      blk_sh_d = blk_sh_q;
      digits_d = digits_q;
      blank_d  = blank_q;
      fv_d     = 1'b0;
      bad_d    = accept && !dec[5];

      if (accept)                        tcnt_d = '0;
      else if (tcnt_q == TW'(TIMEOUT))   tcnt_d = tcnt_q;
      else                               tcnt_d = tcnt_q + TW'(1);
      stale_d = (tcnt_d == TW'(TIMEOUT));

      seen_d = stale_d ? 8'h00 : seen_q;
      if (accept && dec[5]) begin
         dig_sh_d[{idx, 2'b00} +: 4] = dec[3:0];
         blk_sh_d[idx]               = dec[4];
         seen_d[idx]                 = 1'b1;
         if (seen_d == 8'hFF) begin
            digits_d = dig_sh_d;
            blank_d  = blk_sh_d;
            fv_d     = 1'b1;
            seen_d   = 8'h00;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dig_sh_q <= '0;
         blk_sh_q <= 8'hFF;
         digits_q <= '0;
         blank_q  <= 8'hFF;
         seen_q   <= '0;
         tcnt_q   <= '0;
         fv_q     <= 1'b0;
         bad_q    <= 1'b0;
         stale_q  <= 1'b0;
      end else begin
         dig_sh_q <= dig_sh_d;
         blk_sh_q <= blk_sh_d;
         digits_q <= digits_d;
         blank_q  <= blank_d;
         seen_q   <= seen_d;
         tcnt_q   <= tcnt_d;
         fv_q     <= fv_d;
         bad_q    <= bad_d;
         stale_q  <= stale_d;
      end
   end

   assign digits      = digits_q;
   assign blank       = blank_q;
   assign frame_valid = fv_q;
   assign bad_pattern = bad_q;
   assign stale       = stale_q;
endmodule
